// File: rtl/dnn_pkg.sv
// Shared types and constants for the DNN datapath blocks (conv requant,
// max-pool, future FC requant).
package dnn_pkg;

  localparam int ACC_W_DEFAULT = 32;

  // Requantized activation and raw accumulator types.
  typedef logic signed [7:0]               pixel_t;
  typedef logic signed [ACC_W_DEFAULT-1:0] acc_t;

  // Activation range after ReLU and saturation.
  localparam int PIX_MAX = 127;
  localparam int PIX_MIN = 0;

endpackage

// File: rtl/requant_round_sat.sv
// Combinational requant back end: rounding right shift (round half up toward
// +inf), ReLU and saturation to the 0..127 activation range. Shared by the
// conv and FC requant paths.
module requant_round_sat
  import dnn_pkg::*;
#(
  parameter int PROD_W  = 50,
  parameter int SHIFT_W = 5
) (
  input  logic signed [PROD_W-1:0] prod,
  input  logic [SHIFT_W-1:0]       shift,
  output logic signed [7:0]        pixel,
  output logic                     sat_hi
);

  localparam logic signed [PROD_W:0] R_MAX = (PROD_W+1)'(PIX_MAX);

  // One guard bit above the product so adding the half-LSB cannot overflow.
  function automatic logic signed [PROD_W:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [SHIFT_W-1:0]       s
  );
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] half;
    ext  = (PROD_W+1)'(p);
    half = '0;
    if (s == '0) begin
      return ext;
    end
    half[s - 1'b1] = 1'b1;
    return (ext + half) >>> s;
  endfunction

  // Negative values clip to zero (ReLU), large values clip to PIX_MAX.
  function automatic pixel_t clamp(input logic signed [PROD_W:0] r);
    if (r[PROD_W]) begin
      return pixel_t'(PIX_MIN);
    end
    if (r > R_MAX) begin
      return pixel_t'(PIX_MAX);
    end
    return pixel_t'(r[7:0]);
  endfunction

  // Flags outputs that were clipped at the top of the range.
  function automatic logic is_sat_hi(input logic signed [PROD_W:0] r);
    return !r[PROD_W] && (r > R_MAX);
  endfunction

  logic signed [PROD_W:0] rounded;

  // Round, then clamp and flag saturation.
  always_comb begin
    rounded = round_shift(prod, shift);
    pixel   = clamp(rounded);
    sat_hi  = is_sat_hi(rounded);
  end

endmodule

// File: rtl/conv_requant.sv
// Conv accumulator requantization: bias add, fixed-point scale, rounding
// shift, ReLU and saturation into a valid-qualified 8-bit pixel stream with
// per-frame completion. Latency 3 cycles after the accepting edge.
// Optional feature: define CONV_REQUANT_SAT_CNT_EN to build the per-frame
// saturation counter behind sat_count (otherwise sat_count is tied to 0).
module conv_requant
  import dnn_pkg::*;
#(
  parameter int MAP_WIDTH = 28,
  parameter int ACC_W     = 32,
  parameter int SCALE_W   = 16,
  parameter int SHIFT_W   = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic signed [ACC_W-1:0]                  acc_in,
  input  logic signed [ACC_W-1:0]                  bias,
  input  logic [SCALE_W-1:0]                       scale,
  input  logic [SHIFT_W-1:0]                       shift,
  output logic                                     valid_out,
  output logic signed [7:0]                        pixel_out,
  output logic                                     frame_done,
  output logic                                     busy,
  output logic [$clog2(MAP_WIDTH*MAP_WIDTH+1)-1:0] sat_count
);

  localparam int N      = MAP_WIDTH * MAP_WIDTH;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int PROD_W = ACC_W + SCALE_W + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] in_count;
  logic [CNT_W-1:0] out_count;

  // Config latched on the first beat of each frame.
  logic signed [ACC_W-1:0] bias_l;
  logic [SCALE_W-1:0]      scale_l;
  logic [SHIFT_W-1:0]      shift_l;

  logic                    start;
  logic                    frame_end;
  logic signed [ACC_W-1:0] bias_eff;
  logic [SCALE_W-1:0]      scale_eff;
  logic [SHIFT_W-1:0]      shift_eff;

  // Frames in flight: at most two overlap (one draining, one filling).
  logic [1:0] fif;
  logic [1:0] fif_next;

  logic                    vld_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] bias_p0;
  logic [SCALE_W-1:0]      scale_p0;
  logic [SHIFT_W-1:0]      shift_p0;

  logic                    vld_p1;
  logic signed [ACC_W:0]   sum_p1;
  logic [SCALE_W-1:0]      scale_p1;
  logic [SHIFT_W-1:0]      shift_p1;

  logic                     vld_p2;
  logic signed [PROD_W-1:0] prod_p2;
  logic [SHIFT_W-1:0]       shift_p2;

  logic signed [7:0] rs_pixel;
  logic              rs_sat;

  assign start     = valid_in && (in_count == '0);
  assign frame_end = vld_p2 && (out_count == LAST);

  // The first beat of a frame uses the live ports; later beats the latch.
  always_comb begin
    bias_eff  = start ? bias  : bias_l;
    scale_eff = start ? scale : scale_l;
    shift_eff = start ? shift : shift_l;
    fif_next  = fif + {1'b0, start} - {1'b0, frame_end};
  end

  // Control path: valids, counters, config latch, busy and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pixel_out  <= '0;
      in_count   <= '0;
      out_count  <= '0;
      bias_l     <= '0;
      scale_l    <= '0;
      shift_l    <= '0;
      fif        <= '0;
      busy       <= 1'b0;
    end else begin
      vld_p0     <= valid_in;
      vld_p1     <= vld_p0;
      vld_p2     <= vld_p1;
      valid_out  <= vld_p2;
      frame_done <= frame_end;
      if (vld_p2) begin
        pixel_out <= rs_pixel;
        out_count <= (out_count == LAST) ? '0 : out_count + 1'b1;
      end
      if (valid_in) begin
        in_count <= (in_count == LAST) ? '0 : in_count + 1'b1;
      end
      if (start) begin
        bias_l  <= bias;
        scale_l <= scale;
        shift_l <= shift;
      end
      fif  <= fif_next;
      busy <= (fif_next != 2'd0);
    end
  end

  // Stage p0: capture the beat together with the config it must use.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      acc_p0   <= acc_in;
      bias_p0  <= bias_eff;
      scale_p0 <= scale_eff;
      shift_p0 <= shift_eff;
    end
  end

  // Stage p1: bias add with one extra bit so it cannot overflow.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sum_p1   <= (ACC_W+1)'(acc_p0) + (ACC_W+1)'(bias_p0);
      scale_p1 <= scale_p0;
      shift_p1 <= shift_p0;
    end
  end

  // Stage p2: signed sum times unsigned scale at full product width.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      prod_p2  <= PROD_W'(sum_p1) * PROD_W'($signed({1'b0, scale_p1}));
      shift_p2 <= shift_p1;
    end
  end

  // Stage p3 (combinational into pixel_out): round, ReLU, saturate.
  requant_round_sat #(
    .PROD_W  (PROD_W),
    .SHIFT_W (SHIFT_W)
  ) u_round_sat (
    .prod   (prod_p2),
    .shift  (shift_p2),
    .pixel  (rs_pixel),
    .sat_hi (rs_sat)
  );

`ifdef CONV_REQUANT_SAT_CNT_EN
  logic [CNT_W-1:0] sat_acc;

  // Count top-clipped outputs per frame; publish and clear on frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_acc   <= '0;
      sat_count <= '0;
    end else if (frame_end) begin
      sat_count <= sat_acc + CNT_W'(rs_sat);
      sat_acc   <= '0;
    end else if (vld_p2 && rs_sat) begin
      sat_acc <= sat_acc + 1'b1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = rs_sat;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_conv_requant.sv
// Bench for conv_requant: directed steps plus randomized frames checked
// against a plain-arithmetic reference model and an expected-output queue.
module tb_conv_requant;

  localparam int MW    = 28;
  localparam int N     = MW * MW;
  localparam int CNT_W = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    valid_in;
  logic signed [31:0]      acc_in;
  logic signed [31:0]      bias;
  logic [15:0]             scale;
  logic [4:0]              shift;
  logic                    valid_out;
  logic signed [7:0]       pixel_out;
  logic                    frame_done;
  logic                    busy;
  logic [CNT_W-1:0]        sat_count;

  conv_requant #(
    .MAP_WIDTH (MW),
    .ACC_W     (32),
    .SCALE_W   (16),
    .SHIFT_W   (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .acc_in     (acc_in),
    .bias       (bias),
    .scale      (scale),
    .shift      (shift),
    .valid_out  (valid_out),
    .pixel_out  (pixel_out),
    .frame_done (frame_done),
    .busy       (busy),
    .sat_count  (sat_count)
  );

  typedef struct {
    logic [7:0] pix;
    bit         last;
    bit         sat;
  } item_t;

  item_t      q[$];
  item_t      mon_it;
  int         checks = 0;
  int         errors = 0;
  int         fd_count = 0;
  int         sat_run = 0;
  int         exp_sat = 0;
  int         in_idx = 0;
  int         fd0;
  logic [7:0] last_pix = '0;
  longint     lb, ls;
  int         lsh;

`ifdef CONV_REQUANT_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, floor shift after adding half.
  function automatic item_t model(input longint a, input longint b, input longint s,
                                  input int sh, input bit last);
    longint p, r;
    item_t  it;
    p = (a + b) * s;
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
    it.last = last;
    it.sat  = 1'b0;
    if (r < 0)        it.pix = 8'd0;
    else if (r > 127) begin it.pix = 8'd127; it.sat = 1'b1; end
    else              it.pix = r[7:0];
    return it;
  endfunction

  task automatic send(input logic signed [31:0] a);
    @(posedge clk); #1;
    if (in_idx == 0) begin
      lb  = longint'(bias);
      ls  = longint'(scale);
      lsh = int'(shift);
    end
    valid_in = 1'b1;
    acc_in   = a;
    q.push_back(model(longint'(a), lb, ls, lsh, in_idx == N - 1));
    in_idx = (in_idx == N - 1) ? 0 : in_idx + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    q.delete();
    in_idx   = 0;
    sat_run  = 0;
    exp_sat  = 0;
    last_pix = '0;
    rst      = 1'b0;
    chk("busy_after_rst", busy, 0);
    chk("pixel_after_rst", pixel_out, 0);
  endtask

  task automatic single(input string tag, input logic signed [31:0] a, input int expv);
    send(a);
    idle(1);
    repeat (4) @(negedge clk);
    chk(tag, pixel_out, expv);
  endtask

  // Output monitor: every beat against the queue; bubbles hold and stay quiet.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          mon_it = q.pop_front();
          chk("pixel", pixel_out, mon_it.pix);
          chk("frame_done_align", frame_done, mon_it.last);
          last_pix = mon_it.pix;
          if (mon_it.sat) sat_run++;
          if (mon_it.last) begin
            exp_sat = SAT_EN ? sat_run : 0;
            sat_run = 0;
          end
        end
      end else begin
        chk("bubble_frame_done", frame_done, 0);
        chk("bubble_pixel_hold", pixel_out, last_pix);
      end
      if (frame_done) fd_count++;
      chk("sat_count", sat_count, exp_sat);
    end
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    acc_in   = '0;
    bias     = '0;
    scale    = '0;
    shift    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat_count", sat_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic scaling and 3-cycle latency.
    bias = 0; scale = 3; shift = 2;
    send(100);
    idle(1);
    chk("busy_rise", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("latency_valid", valid_out, (i == 4) ? 1 : 0);
    end
    chk("pix_100_s3_sh2", pixel_out, 75);

    // Rounding and ReLU.
    do_reset();
    bias = 0; scale = 1; shift = 2;
    single("round_6", 6, 2);
    single("round_5", 5, 1);
    single("relu_neg", -500, 0);

    // Saturation single beat.
    do_reset();
    bias = 24; scale = 1; shift = 3;
    single("sat_1000", 1000, 127);

    // Full frame of saturating beats.
    do_reset();
    bias = 24; scale = 1; shift = 3;
    fd0 = fd_count;
    for (int i = 0; i < N; i++) send(1000);
    drain();
    chk("sat_frame_done_cnt", fd_count - fd0, 1);
    chk("sat_frame_count", sat_count, SAT_EN ? N : 0);
    chk("busy_after_sat_frame", busy, 0);

    // Ramp frame with random bubbles.
    do_reset();
    bias = 0; scale = 1; shift = 0;
    fd0 = fd_count;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(i);
    end
    drain();
    chk("ramp_frame_done_cnt", fd_count - fd0, 1);
    chk("ramp_last_pixel", last_pix, 127);

    // Two back-to-back frames, different config; ports change mid-frame.
    do_reset();
    fd0 = fd_count;
    for (int j = 0; j < 2 * N; j++) begin
      if (j >= 2) chk("busy_b2b", busy, 1);
      if (j == 0) begin
        bias  = $signed(32'($urandom_range(0, 2000))) - 1000;
        scale = 16'($urandom_range(1, 65535));
        shift = 5'($urandom_range(12, 31));
      end
      if (j % N != 0 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      send($signed($urandom()));
      if (j == 0) begin
        bias  = $signed(32'($urandom_range(0, 2000))) - 1000;
        scale = 16'($urandom_range(1, 65535));
        shift = 5'($urandom_range(0, 20));
      end
    end
    drain();
    chk("b2b_frame_done_cnt", fd_count - fd0, 2);
    chk("busy_after_b2b", busy, 0);

    // Reset after 300 beats, then two full frames.
    do_reset();
    bias = 0; scale = 1; shift = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) idle(1);
      send($signed(32'($urandom_range(0, 400))) - 100);
    end
    do_reset();
    fd0 = fd_count;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(i);
    end
    bias  = -50;
    scale = 16'($urandom_range(1, 255));
    shift = 5'($urandom_range(1, 10));
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send($signed(32'($urandom_range(0, 20000))) - 10000);
    end
    drain();
    chk("post_rst_frame_done_cnt", fd_count - fd0, 2);
    chk("busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
